instr_sequencer: RTL



---
 rtl/proc_pkg.sv | 29 ++
 rtl/instr_sequencer.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/proc_pkg.sv
// Shared definitions for the simple processor and its instruction sequencer:
// sequencer state encoding, opcode constants and the opcode field extractor.
package proc_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH_I,
        S_LATCH_M,
        S_ISSUE,
        S_WAIT,
        S_END
    } seq_state_t;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;

    // Widest instruction word the extractor accepts; callers zero-extend to this.
    localparam int unsigned MAX_WORD_W = 32;

    // Opcode is the top three bits of a word that is dw bits wide.
    function automatic logic [2:0] get_opcode(input logic [MAX_WORD_W-1:0] word,
                                              input int unsigned           dw);
        return word[dw-1 -: 3];
    endfunction

endpackage

// File: rtl/instr_sequencer.sv
// Handshaked instruction fetch engine. Reads words from a synchronous ROM,
// presents each instruction on Din with a one-cycle run pulse (pre-fetching
// the immediate word for mvi), then waits for Done before advancing pc.
module instr_sequencer
    import proc_pkg::*;
#(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 9,
    parameter logic [2:0]  MVI_OP = OP_MVI
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              halt,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic [DATA_W-1:0] Din,
    output logic              run,
    input  logic              Done,
    output logic              busy,
    output logic              prog_end,
    output logic              fetch_err
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    seq_state_t        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic              halt_q, halt_d;
    logic              ferr_q, ferr_d;

    logic              fetched_mvi;
    logic              instr_mvi;
    logic [ADDR_W:0]   pc_step;

    assign fetched_mvi = (get_opcode(MAX_WORD_W'(mem_data), DATA_W) == MVI_OP);
    assign instr_mvi   = (get_opcode(MAX_WORD_W'(instr_q), DATA_W) == MVI_OP);

    // One extra bit so stepping past the last address is seen, never wrapped.
    assign pc_step = {1'b0, pc_q} + (instr_mvi ? (ADDR_W+1)'(2) : (ADDR_W+1)'(1));

    assign Din       = din_q;
    assign fetch_err = ferr_q;

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            instr_q <= '0;
            imm_q   <= '0;
            din_q   <= '0;
            halt_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            imm_q   <= imm_d;
            din_q   <= din_d;
            halt_q  <= halt_d;
            ferr_q  <= ferr_d;
        end
    end

    // Next-state, datapath updates and Moore outputs.
    always_comb begin
        // NOTE: every output and next-state gets a default first, so no latches.
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        imm_d    = imm_q;
        din_d    = din_q;
        ferr_d   = ferr_q;
        busy     = (state_q != S_IDLE) && (state_q != S_END);
        prog_end = (state_q == S_END);
        halt_d   = halt_q | (halt & busy);
        mem_addr = pc_q;
        run      = 1'b0;

        unique case (state_q)
            S_IDLE, S_END: begin
                if (start) begin
                    pc_d    = '0;
                    ferr_d  = 1'b0;
                    halt_d  = 1'b0;
                    state_d = S_FETCH;
                end
            end

            S_FETCH: begin
                state_d = S_LATCH_I;
            end

            S_LATCH_I: begin
                // Address the immediate word while the opcode is decoded.
                mem_addr = pc_q + ADDR_W'(1);
                instr_d  = mem_data;
                if (!fetched_mvi) begin
                    din_d   = mem_data;
                    state_d = S_ISSUE;
                end else if (pc_q != LAST_ADDR) begin
                    state_d = S_LATCH_M;
                end else begin
                    // mvi with no room for its immediate: stop without issuing.
                    ferr_d  = 1'b1;
                    state_d = S_END;
                end
            end

            S_LATCH_M: begin
                imm_d   = mem_data;
                din_d   = instr_q;
                state_d = S_ISSUE;
            end

            S_ISSUE: begin
                run     = 1'b1;
                state_d = S_WAIT;
                if (instr_mvi) begin
                    din_d = imm_q;
                end
            end

            S_WAIT: begin
                if (Done) begin
                    if (pc_step[ADDR_W] || halt_q || halt) begin
                        state_d = S_END;
                    end else begin
                        pc_d    = pc_step[ADDR_W-1:0];
                        state_d = S_FETCH;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
